// File: rtl/player_bullet_if.sv
// Player bullet bus: fire/position inputs from the game core, bullet state and result pulses to the draw pipeline.
// Master drives the request and target side, slave is the bullet controller.
interface player_bullet_if;
  logic       fire;
  logic [9:0] player_x;
  logic [9:0] invader_x;
  logic [9:0] invader_y;
  logic       invader_alive;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       bullet_active;
  logic       hit;
  logic       miss;

  modport master (
    output fire, player_x, invader_x, invader_y, invader_alive,
    input  bullet_x, bullet_y, bullet_active, hit, miss
  );

  modport slave (
    input  fire, player_x, invader_x, invader_y, invader_alive,
    output bullet_x, bullet_y, bullet_active, hit, miss
  );
endinterface

// File: rtl/player_bullet.sv
// Single player bullet: launch on fire, climb SPEED px per tick, one-cycle hit or miss pulse at the end of flight.
// Latency 1 from fire to visible bullet; no backpressure, fire is simply ignored while a bullet is in flight.
module player_bullet #(
  parameter int TICK_DIV = 65_000_000 / 60,
  parameter int SPEED    = 4,
  parameter int START_Y  = 700,
  parameter int BULLET_W = 2,
  parameter int BULLET_H = 8,
  parameter int INV_W    = 32,
  parameter int INV_H    = 16
) (
  input  logic            clk65MHz,
  input  logic            rst,
  player_bullet_if.slave  bus
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    HIT  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic            overlap;
  logic            at_top;
  logic [10:0]     bx;
  logic [10:0]     by;
  logic [10:0]     ix;
  logic [10:0]     iy;

  assign tick = (tick_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk65MHz) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + CW'(1);
  end

  // Widened to 11 bits so a bullet or invader near x/y=1023 cannot wrap the box edges.
  assign bx = {1'b0, bus.bullet_x};
  assign by = {1'b0, bus.bullet_y};
  assign ix = {1'b0, bus.invader_x};
  assign iy = {1'b0, bus.invader_y};

  assign overlap = bus.invader_alive
                && (bx + 11'(BULLET_W) > ix)
                && (bx < ix + 11'(INV_W))
                && (by < iy + 11'(INV_H))
                && (by + 11'(BULLET_H) > iy);

  assign at_top = (bus.bullet_y < 10'(SPEED));

  always_ff @(posedge clk65MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.fire) state_nxt = FLY;
      FLY: begin
        if (overlap)              state_nxt = HIT;
        else if (tick && at_top)  state_nxt = IDLE;
      end
      HIT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.bullet_active = 1'b0;
    bus.hit           = 1'b0;
    case (state)
      FLY:     bus.bullet_active = 1'b1;
      HIT:     bus.hit           = 1'b1;
      default: ;
    endcase
  end

  // Position and miss pulse; a collision freezes the bullet for the cycle it is detected.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      bus.bullet_x <= '0;
      bus.bullet_y <= '0;
      bus.miss     <= 1'b0;
    end else begin
      bus.miss <= (state == FLY) && !overlap && tick && at_top;
      if (state == IDLE && bus.fire) begin
        bus.bullet_x <= bus.player_x;
        bus.bullet_y <= 10'(START_Y);
      end else if (state == FLY && !overlap && tick && !at_top) begin
        bus.bullet_y <= bus.bullet_y - 10'(SPEED);
      end
    end
  end
endmodule

// File: tb/tb_player_bullet.sv
// Bench for player_bullet: directed launch/miss/hit/reset scenarios plus random play, checked every cycle against a behavioural model.
module tb_player_bullet;
  localparam int TICK_DIV = 4;
  localparam int SPEED    = 4;
  localparam int START_Y  = 700;

  logic clk65MHz = 1'b0;
  logic rst      = 1'b1;
  always #5 clk65MHz = ~clk65MHz;

  player_bullet_if bus ();

  player_bullet #(.TICK_DIV(TICK_DIV)) dut (
    .clk65MHz (clk65MHz),
    .rst      (rst),
    .bus      (bus)
  );

  int errs   = 0;
  int checks = 0;
  int hits, misses, steps;

  // Model: bullet described by flight flag, position and pending pulses.
  int m_x, m_y, cyc;
  bit m_act, m_hit, m_miss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit boxes_touch(int bx, int by, int ixx, int iyy, bit alive);
    return alive && (bx + 2 > ixx) && (bx < ixx + 32) && (by < iyy + 16) && (by + 8 > iyy);
  endfunction

  task automatic model_step();
    bit tk;
    bit was_hit;
    tk = (cyc % TICK_DIV) == TICK_DIV - 1;
    if (rst) begin
      m_x = 0; m_y = 0; m_act = 0; m_hit = 0; m_miss = 0; cyc = 0;
      return;
    end
    was_hit = m_hit;
    m_hit   = 0;
    m_miss  = 0;
    if (m_act) begin
      if (boxes_touch(m_x, m_y, int'(bus.invader_x), int'(bus.invader_y), bus.invader_alive)) begin
        m_act = 0; m_hit = 1;
      end else if (tk && m_y < SPEED) begin
        m_act = 0; m_miss = 1;
      end else if (tk) begin
        m_y = m_y - SPEED;
      end
    end else if (!was_hit && bus.fire) begin
      m_act = 1; m_x = int'(bus.player_x); m_y = START_Y;
    end
    cyc++;
  endtask

  task automatic cycle();
    int prev_y;
    prev_y = int'(bus.bullet_y);
    @(posedge clk65MHz);
    model_step();
    @(negedge clk65MHz);
    chk("active", bus.bullet_active, m_act);
    chk("hit",    bus.hit,           m_hit);
    chk("miss",   bus.miss,          m_miss);
    chk("x",      bus.bullet_x,      m_x);
    chk("y",      bus.bullet_y,      m_y);
    chk("hit_miss_excl", bus.hit & bus.miss, 0);
    if (bus.hit)  hits++;
    if (bus.miss) misses++;
    if (bus.bullet_active && int'(bus.bullet_y) == prev_y - SPEED) steps++;
  endtask

  initial begin
    int n;
    bus.fire = 0; bus.player_x = 0; bus.invader_x = 0; bus.invader_y = 0; bus.invader_alive = 0;
    hits = 0; misses = 0; steps = 0;

    rst = 1;
    repeat (3) cycle();
    rst = 0;
    hits = 0; misses = 0;
    repeat (20) cycle();
    chk("idle_pulses", hits + misses, 0);
    chk("idle_active", bus.bullet_active, 0);

    // Launch with dead invader, fly to the top.
    bus.player_x = 500; bus.fire = 1;
    cycle();
    bus.fire = 0;
    chk("launch_act", bus.bullet_active, 1);
    chk("launch_x",   bus.bullet_x, 500);
    chk("launch_y",   bus.bullet_y, 700);
    steps = 0; hits = 0; misses = 0; n = 0;
    while (!bus.miss && n < 2000) begin cycle(); n++; end
    chk("miss_timeout", n < 2000, 1);
    chk("miss_steps",   steps, 175);
    chk("miss_y",       bus.bullet_y, 0);
    chk("miss_no_hit",  hits, 0);
    cycle();
    chk("miss_one_cycle", bus.miss, 0);
    chk("post_miss_act",  bus.bullet_active, 0);

    // Hit path.
    bus.invader_x = 500; bus.invader_y = 600; bus.invader_alive = 1;
    bus.player_x = 510; bus.fire = 1;
    cycle();
    bus.fire = 0;
    steps = 0; hits = 0; misses = 0; n = 0;
    while (!bus.hit && n < 500) begin cycle(); n++; end
    chk("hit_timeout", n < 500, 1);
    chk("hit_steps",   steps, 22);
    chk("hit_y",       bus.bullet_y, 612);
    chk("hit_act",     bus.bullet_active, 0);
    cycle();
    chk("hit_one_cycle", bus.hit, 0);
    repeat (10) cycle();
    chk("hit_no_miss", misses, 0);
    chk("hit_count",   hits, 1);

    // Fire held: no relaunch in flight, relaunch right after the miss.
    bus.invader_alive = 0; bus.player_x = 100; bus.fire = 1;
    cycle();
    misses = 0; n = 0;
    while (!bus.miss && n < 2000) begin cycle(); n++; end
    chk("held_timeout", n < 2000, 1);
    cycle();
    chk("held_relaunch_act", bus.bullet_active, 1);
    chk("held_relaunch_y",   bus.bullet_y, 700);

    // Reset mid-flight at y=400.
    bus.fire = 0; n = 0;
    while (bus.bullet_y != 400 && n < 2000) begin cycle(); n++; end
    chk("y400_timeout", n < 2000, 1);
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_act", bus.bullet_active, 0);
    chk("rst_y",   bus.bullet_y, 0);
    chk("rst_x",   bus.bullet_x, 0);
    hits = 0; misses = 0;
    repeat (8) cycle();
    chk("rst_no_pulse", hits + misses, 0);
    bus.player_x = 300; bus.fire = 1;
    cycle();
    bus.fire = 0;
    chk("relaunch_x", bus.bullet_x, 300);
    chk("relaunch_y", bus.bullet_y, 700);

    // Random play, invader often placed in the bullet's column.
    for (int i = 0; i < 4000; i++) begin
      bus.fire     = ($urandom_range(0, 15) == 0);
      bus.player_x = 10'($urandom_range(0, 1023));
      if (bus.fire && $urandom_range(0, 1) == 1) begin
        bus.invader_x     = (bus.player_x >= 10'd16) ? bus.player_x - 10'($urandom_range(0, 16)) : 10'd0;
        bus.invader_y     = 10'($urandom_range(0, 690));
        bus.invader_alive = 1;
      end else if ($urandom_range(0, 63) == 0) begin
        bus.invader_x     = 10'($urandom_range(0, 1023));
        bus.invader_y     = 10'($urandom_range(0, 1023));
        bus.invader_alive = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
